// File: rtl/s_stream_gen.sv
// s_stream_gen: test-pattern burst generator feeding the SDRAM write FIFO.
// Emits fixed-length, atomic bursts of pattern words while gen_en is high.
// The pattern state carries over between back-to-back bursts of one session,
// so a read-back checker can predict the entire stream from the first seed.
module s_stream_gen #(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 256,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              gen_en,
    input  logic [1:0]        mode,
    input  logic              fifo_full,
    output logic              fifo_wrreq,
    output logic [DATA_W-1:0] fifo_data,
    output logic              busy,
    output logic              burst_done,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int BC_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
    localparam logic [BC_W-1:0]   LAST_IDX = BC_W'(BURST_LEN - 1);
    localparam logic [BC_W-1:0]   BC_ONE   = BC_W'(1);
    localparam logic [BC_W-1:0]   BC_ZERO  = BC_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [DATA_W-1:0] PAT_ZERO = DATA_W'(0);
    localparam logic [DATA_W-1:0] PAT_ONE  = DATA_W'(1);
    localparam logic [DATA_W-1:0] ALT_SEED = DATA_W'({(DATA_W/2){2'b10}});

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // First word of a new session for the selected pattern.
    function automatic logic [DATA_W-1:0] seed_f(input logic [1:0] m);
        logic [DATA_W-1:0] s;
        case (m)
            2'd0:    s = PAT_ZERO;
            2'd1:    s = PAT_ONE;
            2'd2:    s = PAT_ONE;
            2'd3:    s = ALT_SEED;
            default: s = PAT_ZERO;
        endcase
        return s;
    endfunction

    // Successor of the current word for the selected pattern. The LFSR taps
    // stay on bits 15..10 regardless of DATA_W so the sequence is portable.
    function automatic logic [DATA_W-1:0] adv_f(input logic [1:0] m,
                                                input logic [DATA_W-1:0] cur);
        logic [DATA_W-1:0] n;
        case (m)
            2'd0:    n = cur + PAT_ONE;
            2'd1:    n = {cur[DATA_W-2:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
            2'd2:    n = {cur[DATA_W-2:0], cur[DATA_W-1]};
            2'd3:    n = ~cur;
            default: n = cur;
        endcase
        return n;
    endfunction

    state_t            state_r, state_s;
    logic [1:0]        mode_r, mode_s;
    logic              new_sess_r, new_sess_s;
    logic [DATA_W-1:0] pat_r, pat_s;
    logic [BC_W-1:0]   bcnt_r, bcnt_s;
    logic [CNT_W-1:0]  word_cnt_r, word_cnt_s;
    logic              busy_r;
    logic              burst_done_r;
    logic              wr_s;

    // Write handshake: the only combinational output path.
    always_comb begin
        wr_s = (state_r == ST_RUN) && !fifo_full;
    end

    // Next-state and next-datapath logic; every register holds by default.
    always_comb begin
        state_s    = state_r;
        mode_s     = mode_r;
        new_sess_s = new_sess_r;
        pat_s      = pat_r;
        bcnt_s     = bcnt_r;
        word_cnt_s = word_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (gen_en) begin
                    state_s    = ST_LOAD;
                    new_sess_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                mode_s  = mode;
                bcnt_s  = BC_ZERO;
                state_s = ST_RUN;
                if (new_sess_r) begin
                    pat_s = seed_f(mode);
                end else begin
                    pat_s = pat_r;
                end
            end
            ST_RUN: begin
                if (wr_s) begin
                    pat_s      = adv_f(mode_r, pat_r);
                    bcnt_s     = bcnt_r + BC_ONE;
                    word_cnt_s = word_cnt_r + CNT_ONE;
                    if (bcnt_r == LAST_IDX) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (gen_en) begin
                    state_s    = ST_LOAD;
                    new_sess_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, pattern and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r      <= ST_IDLE;
            mode_r       <= 2'd0;
            new_sess_r   <= 1'b0;
            pat_r        <= PAT_ZERO;
            bcnt_r       <= BC_ZERO;
            word_cnt_r   <= CNT_ZERO;
            busy_r       <= 1'b0;
            burst_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            mode_r       <= mode_s;
            new_sess_r   <= new_sess_s;
            pat_r        <= pat_s;
            bcnt_r       <= bcnt_s;
            word_cnt_r   <= word_cnt_s;
            busy_r       <= (state_s != ST_IDLE);
            burst_done_r <= (state_s == ST_DONE);
        end
    end

    assign fifo_wrreq = wr_s;
    assign fifo_data  = pat_r;
    assign busy       = busy_r;
    assign burst_done = burst_done_r;
    assign word_cnt   = word_cnt_r;

endmodule

// File: tb/tb_s_stream_gen.sv
// Directed bench for s_stream_gen: three instances (burst lengths 4, 8, 256)
// share clock and reset; each scenario task checks its own expectations.
module tb_s_stream_gen;

    logic clk;
    logic n_rst;

    logic        ge4, ff4, wr4, busy4, bd4;
    logic [1:0]  md4;
    logic [15:0] d4;
    logic [31:0] wc4;

    logic        ge8, ff8, wr8, busy8, bd8;
    logic [1:0]  md8;
    logic [15:0] d8;
    logic [31:0] wc8;

    logic        geL, ffL, wrL, busyL, bdL;
    logic [1:0]  mdL;
    logic [15:0] dL;
    logic [31:0] wcL;

    int n_tests;
    int n_fail;

    s_stream_gen #(.DATA_W(16), .BURST_LEN(4), .CNT_W(32)) dut4 (
        .clk(clk), .n_rst(n_rst), .gen_en(ge4), .mode(md4), .fifo_full(ff4),
        .fifo_wrreq(wr4), .fifo_data(d4), .busy(busy4), .burst_done(bd4),
        .word_cnt(wc4)
    );

    s_stream_gen #(.DATA_W(16), .BURST_LEN(8), .CNT_W(32)) dut8 (
        .clk(clk), .n_rst(n_rst), .gen_en(ge8), .mode(md8), .fifo_full(ff8),
        .fifo_wrreq(wr8), .fifo_data(d8), .busy(busy8), .burst_done(bd8),
        .word_cnt(wc8)
    );

    s_stream_gen #(.DATA_W(16), .BURST_LEN(256), .CNT_W(32)) dutL (
        .clk(clk), .n_rst(n_rst), .gen_en(geL), .mode(mdL), .fifo_full(ffL),
        .fifo_wrreq(wrL), .fifo_data(dL), .busy(busyL), .burst_done(bdL),
        .word_cnt(wcL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset;
        n_rst = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    task automatic wait_idle(input int which);
        logic b;
        b = 1'b1;
        for (int c = 0; c < 40 && b; c++) begin
            tick();
            b = (which == 8) ? busy8 : busy4;
        end
        n_tests++;
        if (b !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle_%0d: busy=%b required 0 within 40 cycles", which, b);
        end
    endtask

    task automatic test_reset;
        apply_reset();
        n_tests++;
        if ({wr4, busy4, bd4, wc4, d4} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset_dut4: wr=%b busy=%b bd=%b wc=%0d d=%h required all 0", wr4, busy4, bd4, wc4, d4);
        end
        n_tests++;
        if ({wr8, busy8, bd8, wc8, d8} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset_dut8: wr=%b busy=%b bd=%b wc=%0d d=%h required all 0", wr8, busy8, bd8, wc8, d8);
        end
        n_tests++;
        if ({wrL, busyL, bdL, wcL, dL} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset_dutL: wr=%b busy=%b bd=%b wc=%0d d=%h required all 0", wrL, busyL, bdL, wcL, dL);
        end
    endtask

    // Single-cycle gen_en pulse, incrementing pattern, one burst of 4.
    task automatic test_single_burst;
        ge4 = 1'b1; md4 = 2'd0;
        tick();
        ge4 = 1'b0;
        n_tests++;
        if (wr4 !== 1'b0 || busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_load: wr=%b busy=%b required wr=0 busy=1", wr4, busy4);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (wr4 !== 1'b1 || d4 !== 16'(i)) begin
                n_fail++;
                $display("FAIL t1_word%0d: wr=%b d=%h required wr=1 d=%h", i, wr4, d4, 16'(i));
            end
        end
        tick();
        n_tests++;
        if (bd4 !== 1'b1 || wr4 !== 1'b0 || wc4 !== 32'd4) begin
            n_fail++;
            $display("FAIL t1_done: bd=%b wr=%b wc=%0d required bd=1 wr=0 wc=4", bd4, wr4, wc4);
        end
        tick();
        n_tests++;
        if (bd4 !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_idle: bd=%b busy=%b required 0 0", bd4, busy4);
        end
    endtask

    // gen_en held: two bursts with a 2-cycle gap, then a forced 0xFFFF wrap.
    task automatic test_back_to_back;
        apply_reset();
        ge4 = 1'b1; md4 = 2'd0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (wr4 !== 1'b1 || d4 !== 16'(i)) begin
                n_fail++;
                $display("FAIL t2_a%0d: wr=%b d=%h required wr=1 d=%h", i, wr4, d4, 16'(i));
            end
        end
        tick();
        n_tests++;
        if (bd4 !== 1'b1 || wr4 !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_gap_done: bd=%b wr=%b required 1 0", bd4, wr4);
        end
        tick();
        n_tests++;
        if (bd4 !== 1'b0 || wr4 !== 1'b0 || busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL t2_gap_load: bd=%b wr=%b busy=%b required 0 0 1", bd4, wr4, busy4);
        end
        for (int i = 4; i < 8; i++) begin
            tick();
            n_tests++;
            if (wr4 !== 1'b1 || d4 !== 16'(i)) begin
                n_fail++;
                $display("FAIL t2_b%0d: wr=%b d=%h required wr=1 d=%h", i, wr4, d4, 16'(i));
            end
        end
        tick();
        n_tests++;
        if (bd4 !== 1'b1 || wc4 !== 32'd8) begin
            n_fail++;
            $display("FAIL t2_done2: bd=%b wc=%0d required bd=1 wc=8", bd4, wc4);
        end
        ff4 = 1'b1;
        tick();
        tick();
        n_tests++;
        if (wr4 !== 1'b0 || d4 !== 16'h0008) begin
            n_fail++;
            $display("FAIL t2_cont: wr=%b d=%h required wr=0 d=0008", wr4, d4);
        end
        force dut4.pat_r = 16'hFFFF;
        tick();
        n_tests++;
        if (wr4 !== 1'b0 || d4 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL t2_forced: wr=%b d=%h required wr=0 d=ffff", wr4, d4);
        end
        release dut4.pat_r;
        ff4 = 1'b0;
        ge4 = 1'b0;
        #1;
        n_tests++;
        if (wr4 !== 1'b1 || d4 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL t2_ffff: wr=%b d=%h required wr=1 d=ffff", wr4, d4);
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (wr4 !== 1'b1 || d4 !== 16'h0000) begin
            n_fail++;
            $display("FAIL t2_wrap: wr=%b d=%h required wr=1 d=0000", wr4, d4);
        end
        wait_idle(4);
        n_tests++;
        if (wc4 !== 32'd12) begin
            n_fail++;
            $display("FAIL t2_wc: wc=%0d required 12", wc4);
        end
    endtask

    // LFSR: first five words, then the full 65535-word period.
    task automatic test_lfsr;
        logic [15:0] first [5];
        logic [15:0] w65536;
        int cnt;
        int zeros;
        logic [15:0] exp_first [5];
        exp_first[0] = 16'h0001; exp_first[1] = 16'h0002; exp_first[2] = 16'h0004;
        exp_first[3] = 16'h0008; exp_first[4] = 16'h0010;
        for (int i = 0; i < 5; i++) first[i] = 16'hDEAD;
        w65536 = 16'hDEAD;
        cnt = 0;
        zeros = 0;
        geL = 1'b1; mdL = 2'd1; ffL = 1'b0;
        for (int c = 0; c < 70000 && cnt < 65536; c++) begin
            tick();
            if (wrL) begin
                if (cnt < 5) first[cnt] = dL;
                if (cnt < 65535 && dL == 16'h0000) zeros++;
                if (cnt == 65535) w65536 = dL;
                cnt++;
                if (cnt == 65536) geL = 1'b0;
            end
        end
        n_tests++;
        if (cnt != 65536) begin
            n_fail++;
            $display("FAIL t3_timeout: words=%0d required 65536", cnt);
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (first[i] !== exp_first[i]) begin
                n_fail++;
                $display("FAIL t3_word%0d: d=%h required %h", i, first[i], exp_first[i]);
            end
        end
        n_tests++;
        if (zeros != 0) begin
            n_fail++;
            $display("FAIL t3_nozero: zero words=%0d required 0", zeros);
        end
        n_tests++;
        if (w65536 !== 16'h0001) begin
            n_fail++;
            $display("FAIL t3_period: word65536=%h required 0001", w65536);
        end
        tick();
        n_tests++;
        if (bdL !== 1'b1 || wcL !== 32'd65536) begin
            n_fail++;
            $display("FAIL t3_done: bd=%b wc=%0d required bd=1 wc=65536", bdL, wcL);
        end
        tick();
        n_tests++;
        if (busyL !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_idle: busy=%b required 0", busyL);
        end
    endtask

    // Alternating pattern with a 3-cycle full stall on word 3.
    task automatic test_full_stall;
        ge4 = 1'b1; md4 = 2'd3;
        tick();
        ge4 = 1'b0;
        tick();
        n_tests++;
        if (wr4 !== 1'b1 || d4 !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL t4_w1: wr=%b d=%h required wr=1 d=aaaa", wr4, d4);
        end
        tick();
        n_tests++;
        if (wr4 !== 1'b1 || d4 !== 16'h5555) begin
            n_fail++;
            $display("FAIL t4_w2: wr=%b d=%h required wr=1 d=5555", wr4, d4);
        end
        tick();
        ff4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1;
            n_tests++;
            if (wr4 !== 1'b0 || d4 !== 16'hAAAA || wc4 !== 32'd14) begin
                n_fail++;
                $display("FAIL t4_full%0d: wr=%b d=%h wc=%0d required wr=0 d=aaaa wc=14", i, wr4, d4, wc4);
            end
        end
        tick();
        ff4 = 1'b0;
        #1;
        n_tests++;
        if (wr4 !== 1'b1 || d4 !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL t4_w3: wr=%b d=%h required wr=1 d=aaaa", wr4, d4);
        end
        tick();
        n_tests++;
        if (wr4 !== 1'b1 || d4 !== 16'h5555) begin
            n_fail++;
            $display("FAIL t4_w4: wr=%b d=%h required wr=1 d=5555", wr4, d4);
        end
        tick();
        n_tests++;
        if (bd4 !== 1'b1 || wc4 !== 32'd16) begin
            n_fail++;
            $display("FAIL t4_done: bd=%b wc=%0d required bd=1 wc=16", bd4, wc4);
        end
        wait_idle(4);
    endtask

    // Walking one, gen_en dropped mid-burst; burst still completes.
    task automatic test_drop_enable;
        ge8 = 1'b1; md8 = 2'd2; ff8 = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 1) ge8 = 1'b0;
            n_tests++;
            if (wr8 !== 1'b1 || d8 !== (16'h0001 << i)) begin
                n_fail++;
                $display("FAIL t5_w%0d: wr=%b d=%h required wr=1 d=%h", i, wr8, d8, 16'h0001 << i);
            end
        end
        tick();
        n_tests++;
        if (bd8 !== 1'b1 || wc8 !== 32'd8) begin
            n_fail++;
            $display("FAIL t5_done: bd=%b wc=%0d required bd=1 wc=8", bd8, wc8);
        end
        tick();
        n_tests++;
        if (busy8 !== 1'b0 || wr8 !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_idle: busy=%b wr=%b required 0 0", busy8, wr8);
        end
        ge8 = 1'b1;
        tick();
        ge8 = 1'b0;
        tick();
        n_tests++;
        if (wr8 !== 1'b1 || d8 !== 16'h0001) begin
            n_fail++;
            $display("FAIL t5_reseed: wr=%b d=%h required wr=1 d=0001", wr8, d8);
        end
        wait_idle(8);
    endtask

    // Reset asserted mid-RUN abandons the burst; next session reseeds.
    task automatic test_reset_mid_run;
        ge4 = 1'b1; md4 = 2'd0;
        tick();
        ge4 = 1'b0;
        tick();
        tick();
        n_tests++;
        if (wr4 !== 1'b1 || d4 !== 16'h0001) begin
            n_fail++;
            $display("FAIL t6_pre: wr=%b d=%h required wr=1 d=0001", wr4, d4);
        end
        n_rst = 1'b0;
        tick();
        n_tests++;
        if ({wr4, busy4, bd4, wc4, d4} !== 51'd0) begin
            n_fail++;
            $display("FAIL t6_rst: wr=%b busy=%b bd=%b wc=%0d d=%h required all 0", wr4, busy4, bd4, wc4, d4);
        end
        n_rst = 1'b1;
        ge4 = 1'b1; md4 = 2'd1;
        tick();
        ge4 = 1'b0;
        tick();
        n_tests++;
        if (wr4 !== 1'b1 || d4 !== 16'h0001) begin
            n_fail++;
            $display("FAIL t6_restart: wr=%b d=%h required wr=1 d=0001", wr4, d4);
        end
        tick();
        n_tests++;
        if (d4 !== 16'h0002 || wc4 !== 32'd1) begin
            n_fail++;
            $display("FAIL t6_next: d=%h wc=%0d required d=0002 wc=1", d4, wc4);
        end
        wait_idle(4);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        n_rst = 1'b0;
        ge4 = 1'b0; md4 = 2'd0; ff4 = 1'b0;
        ge8 = 1'b0; md8 = 2'd0; ff8 = 1'b0;
        geL = 1'b0; mdL = 2'd0; ffL = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_lfsr();
        test_full_stall();
        test_drop_enable();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
